fp_addsub_seq: RTL and testbench

// Parametrised multi-cycle floating-point add/subtract unit: FSM and datapath in one block.

---
 rtl/fp_addsub_seq.sv | 162 ++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle floating-point add/subtract with valid/ready handshake
// Flow: IDLE -> ALIGN -> ADD -> NORM (1+k cycles) -> ROUND -> DONE, denormals flushed to zero.

module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MX = MAN_W + 4;   // hidden, mantissa, guard, round, sticky

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t           state, state_n;
    logic             sign_a, sign_b, sign_r, eff_sub;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic [EXP_W:0]   exp_r;
    logic [MX-1:0]    mb, ms;
    logic [MX:0]      sum_r;

    logic             a_ge_b, big_s, sticky;
    logic [EXP_W-1:0] big_e, small_e, diff;
    logic [MAN_W-1:0] big_m, small_m;
    logic [MX-1:0]    big_ext, small_ext, aligned;
    logic [2*MX-1:0]  wide;
    logic [MX:0]      sum_n;
    logic             sum_zero, exp_one;
    logic             inc, ovf_rnd;
    logic [MAN_W:0]   rnd;
    logic [EXP_W:0]   exp_rnd;
    logic [W-1:0]     res_rnd;

    always_comb begin
        a_ge_b    = {exp_a, man_a} >= {exp_b, man_b};
        big_s     = a_ge_b ? sign_a : sign_b;
        big_e     = a_ge_b ? exp_a : exp_b;
        big_m     = a_ge_b ? man_a : man_b;
        small_e   = a_ge_b ? exp_b : exp_a;
        small_m   = a_ge_b ? man_b : man_a;
        big_ext   = {big_e != '0, big_m, 3'b000};
        small_ext = {small_e != '0, small_m, 3'b000};
        diff      = big_e - small_e;
        // Lower half of wide catches the shifted-out bits; huge shifts lose everything to sticky.
        wide      = {small_ext, {MX{1'b0}}} >> diff;
        sticky    = (int'(diff) >= MX) ? |small_ext : |wide[MX-1:0];
        aligned   = {wide[2*MX-1:MX+1], wide[MX] | sticky};

        sum_n     = eff_sub ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
        sum_zero  = (sum_r == '0);
        exp_one   = (exp_r == (EXP_W+1)'(1));

        // Hidden bit is always set on entry to ROUND, so a cleared hidden bit means wrap-around.
        inc       = sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
        rnd       = sum_r[MX-1:3] + {{MAN_W{1'b0}}, inc};
        exp_rnd   = exp_r + {{EXP_W{1'b0}}, ~rnd[MAN_W]};
        ovf_rnd   = exp_rnd >= {1'b0, {EXP_W{1'b1}}};
        res_rnd   = ovf_rnd ? {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {sign_r, exp_rnd[EXP_W-1:0], rnd[MAN_W-1:0]};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_n = S_ALIGN;
            end
            S_ALIGN: state_n = S_ADD;
            S_ADD:   state_n = S_NORM;
            S_NORM: begin
                if (sum_zero)                  state_n = S_DONE;
                else if (sum_r[MX] || sum_r[MX-1]) state_n = S_ROUND;
                else if (exp_one)              state_n = S_DONE;
            end
            S_ROUND: state_n = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            exp_a  <= '0;
            exp_b  <= '0;
            man_a  <= '0;
            man_b  <= '0;
            sign_r <= 1'b0;
            eff_sub <= 1'b0;
            exp_r  <= '0;
            mb     <= '0;
            ms     <= '0;
            sum_r  <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    sign_a <= a[W-1];
                    exp_a  <= a[W-2:MAN_W];
                    man_a  <= (a[W-2:MAN_W] == '0) ? '0 : a[MAN_W-1:0];
                    sign_b <= b[W-1] ^ sub;
                    exp_b  <= b[W-2:MAN_W];
                    man_b  <= (b[W-2:MAN_W] == '0) ? '0 : b[MAN_W-1:0];
                end
                S_ALIGN: begin
                    sign_r  <= big_s;
                    eff_sub <= sign_a ^ sign_b;
                    exp_r   <= {1'b0, big_e};
                    mb      <= big_ext;
                    ms      <= aligned;
                end
                S_ADD: sum_r <= sum_n;
                S_NORM: begin
                    if (sum_zero || (!sum_r[MX] && !sum_r[MX-1] && exp_one)) begin
                        result <= '0;
                        ovf    <= 1'b0;
                    end else if (sum_r[MX]) begin
                        sum_r <= {1'b0, sum_r[MX:2], sum_r[1] | sum_r[0]};
                        exp_r <= exp_r + 1'b1;
                    end else if (!sum_r[MX-1]) begin
                        sum_r <= {sum_r[MX-1:0], 1'b0};
                        exp_r <= exp_r - 1'b1;
                    end
                end
                S_ROUND: begin
                    result <= res_rnd;
                    ovf    <= ovf_rnd;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - scoreboard bench for fp_addsub_seq against a real-arithmetic model
// Expected results come from IEEE double addition followed by round-to-nearest-even to single.

module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        ovf;
    logic        busy;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    bit   rand_mode = 0;
    bit   first_seen = 0;
    bit   after_xfer = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic real fval(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic void model(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                                  output logic [31:0] r, output logic o);
        real             s;
        logic [63:0]     d;
        int              e;
        longint unsigned m, qv, rem;
        r = 32'd0;
        o = 1'b0;
        s = fval(xa) + (xs ? -fval(xb) : fval(xb));
        if (s == 0.0) return;
        d = $realtobits(s);
        e = int'(d[62:52]) - 1023 + 127;
        if (e < 1) return;
        m   = {11'd0, 1'b1, d[51:0]};
        qv  = m >> 29;
        rem = m & 64'h1FFF_FFFF;
        if (rem > 64'h1000_0000 || (rem == 64'h1000_0000 && qv[0])) qv++;
        if (qv == 64'h100_0000) begin
            qv = qv >> 1;
            e++;
        end
        if (e >= 255) begin
            r = {d[63], 8'hFF, 23'd0};
            o = 1'b1;
        end else begin
            r = {d[63], 8'(e), qv[22:0]};
        end
    endfunction

    // Monitor: drives out_ready for the coming cycle, then checks whatever the DUT presents.
    always @(negedge clk) begin
        if (clr) begin
            first_seen = 0;
            after_xfer = 0;
        end else begin
            if (stall_cnt > 0 && out_valid) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (after_xfer) begin
                check("out_valid_single_cycle", 32'(out_valid), 32'd0);
                check("in_ready_after_xfer", 32'(in_ready), 32'd1);
                after_xfer = 0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: result=%0h, expected no output", result);
                end else begin
                    if (!first_seen) begin
                        first_seen = 1;
                        if (sb[0].lat >= 0)
                            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    end
                    check("result", result, sb[0].res);
                    check("ovf", 32'(ovf), 32'(sb[0].ovf));
                    check("in_ready_while_valid", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        first_seen = 0;
                        after_xfer = 1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [31:0] eres, input logic eovf, input int lat, input bit push);
        int   k = 0;
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        sub = isub;
        in_valid = 1'b1;
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.res = eres;
            e.ovf = eovf;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
        end
        // Junk operands with in_valid still high while busy must be ignored.
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [7:0]  ea, eb;
    logic [31:0] ra, rb, er;
    logic        eo, rs;
    int          t;

    initial begin
        clr = 1'b1;
        in_valid = 1'b0;
        a = 32'd0;
        b = 32'd0;
        sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        #1 clr = 1'b0;

        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 4, 1);
        issue(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 6, 1);
        issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 3, 1);
        issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 4, 1);
        issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 4, 1);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4, 1);
        issue(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, -1, 1);
        drain();

        stall_cnt = 5;
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 4, 1);
        drain();

        issue(32'h3FC00000, 32'h3FA00000, 1'b1, 32'd0, 1'b0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("busy_before_clr", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_result", result, 32'd0);
        check("clr_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #1 clr = 1'b0;
        repeat (12) @(negedge clk);

        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            ea = 8'($urandom_range(0, 255));
            ra = {1'($urandom), ea, 23'($urandom)};
            case ($urandom_range(0, 3))
                0: begin
                    eb = 8'($urandom_range(0, 255));
                    rb = {1'($urandom), eb, 23'($urandom)};
                end
                1, 2: begin
                    t = int'(ea) + int'($urandom_range(0, 60)) - 30;
                    if (t < 0) t = 0;
                    if (t > 255) t = 255;
                    rb = {1'($urandom), 8'(t), 23'($urandom)};
                end
                default: rb = {1'($urandom), ea, ra[22:0] ^ 23'($urandom_range(0, 15))};
            endcase
            rs = 1'($urandom);
            model(ra, rb, rs, er, eo);
            issue(ra, rb, rs, er, eo, -1, 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
